// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, condition codes, branch/cmov condition and E->M pipeline register
module exe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         bubble,
  input  logic         cc_block,
  input  logic [3:0]   icode,
  input  logic [3:0]   alufun,
  input  logic [3:0]   cond,
  input  logic         set_cc,
  input  logic [W-1:0] aluA,
  input  logic [W-1:0] aluB,
  input  logic [W-1:0] valA,
  input  logic [3:0]   dstE,
  output logic         out_valid,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic [3:0]   out_dstE,
  output logic         out_cnd,
  output logic [2:0]   cc
);

  localparam logic [3:0] NOP_ICODE = 4'h1;
  localparam logic [3:0] NO_REG    = 4'hF;

  logic         r_valid;
  logic [3:0]   r_icode;
  logic [W-1:0] r_valE;
  logic [W-1:0] r_valA;
  logic [3:0]   r_dstE;
  logic         r_cnd;
  logic [2:0]   r_cc;

  logic [W-1:0] w_result;
  logic         w_zf;
  logic         w_sf;
  logic         w_of;
  logic         w_cnd;
  logic         w_cur_zf;
  logic         w_cur_sf;
  logic         w_cur_of;
  logic         w_load;
  logic         w_cc_we;

  always_comb begin
    w_result = '0;
    w_of     = 1'b0;
    case (alufun)
      4'd0: begin
        w_result = aluA + aluB;
        w_of = (aluA[W-1] == aluB[W-1]) && (w_result[W-1] != aluA[W-1]);
      end
      4'd1: begin
        w_result = aluA - aluB;
        w_of = (aluA[W-1] != aluB[W-1]) && (w_result[W-1] != aluA[W-1]);
      end
      4'd2: w_result = aluA & aluB;
      4'd3: w_result = aluA ^ aluB;
      default: w_result = '0;
    endcase
  end

  assign w_zf = (w_result == '0);
  assign w_sf = w_result[W-1];

  // Condition uses the architectural flags before this instruction's update
  assign {w_cur_zf, w_cur_sf, w_cur_of} = r_cc;

  always_comb begin
    w_cnd = 1'b0;
    case (cond)
      4'd0: w_cnd = 1'b1;
      4'd1: w_cnd = (w_cur_sf ^ w_cur_of) | w_cur_zf;
      4'd2: w_cnd = w_cur_sf ^ w_cur_of;
      4'd3: w_cnd = w_cur_zf;
      4'd4: w_cnd = ~w_cur_zf;
      4'd5: w_cnd = ~(w_cur_sf ^ w_cur_of);
      4'd6: w_cnd = ~(w_cur_sf ^ w_cur_of) & ~w_cur_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  assign w_load  = in_valid && !bubble;
  assign w_cc_we = in_valid && set_cc && !bubble && !cc_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_icode <= NOP_ICODE;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= NO_REG;
      r_cnd   <= 1'b0;
      r_cc    <= 3'b100;
    end else if (!stall) begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_icode <= icode;
        r_valE  <= w_result;
        r_valA  <= valA;
        r_dstE  <= w_cnd ? dstE : NO_REG;
        r_cnd   <= w_cnd;
      end else begin
        r_valid <= 1'b0;
        r_icode <= NOP_ICODE;
        r_valE  <= '0;
        r_valA  <= '0;
        r_dstE  <= NO_REG;
        r_cnd   <= 1'b0;
      end
      if (w_cc_we) begin
        r_cc <= {w_zf, w_sf, w_of};
      end
    end
  end

  assign out_valid = r_valid;
  assign out_icode = r_icode;
  assign out_valE  = r_valE;
  assign out_valA  = r_valA;
  assign out_dstE  = r_dstE;
  assign out_cnd   = r_cnd;
  assign cc        = r_cc;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         stall;
  logic         bubble;
  logic         cc_block;
  logic [3:0]   icode;
  logic [3:0]   alufun;
  logic [3:0]   cond;
  logic         set_cc;
  logic [W-1:0] aluA;
  logic [W-1:0] aluB;
  logic [W-1:0] valA;
  logic [3:0]   dstE;
  logic         out_valid;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic [3:0]   out_dstE;
  logic         out_cnd;
  logic [2:0]   cc;

  int checks   = 0;
  int failures = 0;

  exe_stage #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .bubble(bubble),
    .cc_block(cc_block), .icode(icode), .alufun(alufun), .cond(cond),
    .set_cc(set_cc), .aluA(aluA), .aluB(aluB), .valA(valA), .dstE(dstE),
    .out_valid(out_valid), .out_icode(out_icode), .out_valE(out_valE),
    .out_valA(out_valA), .out_dstE(out_dstE), .out_cnd(out_cnd), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] cd, input logic sc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] va, input logic [3:0] d);
    in_valid = v; icode = ic; alufun = fn; cond = cd; set_cc = sc;
    aluA = a; aluB = b; valA = va; dstE = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_icode"}, out_icode, 4'h1);
    chk({tag, "_valE"},  out_valE, 32'h0);
    chk({tag, "_valA"},  out_valA, 32'h0);
    chk({tag, "_dstE"},  out_dstE, 4'hF);
    chk({tag, "_cnd"},   out_cnd, 1'b0);
    chk({tag, "_cc"},    cc, 3'b100);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; bubble = 1'b0; cc_block = 1'b0;
    set_in(1'b1, 4'h6, 4'd0, 4'd0, 1'b1, 32'h5, 32'h6, 32'h7, 4'h2);
    tick();
    chk_reset_state("reset");

    rst = 1'b0; stall = 1'b0;
    // add overflow
    set_in(1'b1, 4'h6, 4'd0, 4'd0, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h55, 4'h2);
    tick();
    chk("add_valE", out_valE, 32'h80000000);
    chk("add_cc", cc, 3'b011);
    chk("add_valid", out_valid, 1'b1);
    chk("add_icode", out_icode, 4'h6);
    chk("add_valA", out_valA, 32'h55);
    chk("add_dstE", out_dstE, 4'h2);
    chk("add_cnd", out_cnd, 1'b1);

    // sub to zero: its own cond=e sees the old flags (ZF=0)
    set_in(1'b1, 4'h6, 4'd1, 4'd3, 1'b1, 32'h12345678, 32'h12345678, 32'h0, 4'h4);
    tick();
    chk("subz_valE", out_valE, 32'h0);
    chk("subz_cc", cc, 3'b100);
    chk("subz_own_cnd", out_cnd, 1'b0);
    chk("subz_own_dstE", out_dstE, 4'hF);

    set_in(1'b1, 4'h2, 4'd0, 4'd3, 1'b0, 32'h1, 32'h2, 32'h0, 4'h5);
    tick();
    chk("e_cnd", out_cnd, 1'b1);
    chk("e_valE", out_valE, 32'h3);
    chk("e_dstE", out_dstE, 4'h5);

    set_in(1'b1, 4'h2, 4'd0, 4'd4, 1'b0, 32'h1, 32'h2, 32'h0, 4'h5);
    tick();
    chk("ne_cnd", out_cnd, 1'b0);
    chk("ne_dstE", out_dstE, 4'hF);

    // 0 - 1 -> FFFFFFFF, SF only
    set_in(1'b1, 4'h6, 4'd1, 4'd0, 1'b1, 32'h0, 32'h1, 32'h0, 4'h1);
    tick();
    chk("neg_valE", out_valE, 32'hFFFFFFFF);
    chk("neg_cc", cc, 3'b010);

    set_in(1'b1, 4'h2, 4'd0, 4'd6, 1'b0, 32'h0, 32'h0, 32'h0, 4'h3);
    tick();
    chk("g_cnd", out_cnd, 1'b0);
    chk("g_dstE", out_dstE, 4'hF);

    set_in(1'b1, 4'h2, 4'd0, 4'd2, 1'b0, 32'h0, 32'h0, 32'h0, 4'h3);
    tick();
    chk("l_cnd", out_cnd, 1'b1);
    chk("l_dstE", out_dstE, 4'h3);

    set_in(1'b1, 4'h2, 4'd0, 4'd1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h3);
    tick();
    chk("le_cnd", out_cnd, 1'b1);

    set_in(1'b1, 4'h2, 4'd0, 4'd5, 1'b0, 32'h0, 32'h0, 32'h0, 4'h3);
    tick();
    chk("ge_cnd", out_cnd, 1'b0);

    set_in(1'b1, 4'h2, 4'd0, 4'd7, 1'b0, 32'h0, 32'h0, 32'h0, 4'h3);
    tick();
    chk("cond7_cnd", out_cnd, 1'b0);
    chk("cond7_dstE", out_dstE, 4'hF);

    // xor, then stall / stall+bubble / bubble
    set_in(1'b1, 4'h6, 4'd3, 4'd0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h11, 4'h6);
    tick();
    chk("xor_valE", out_valE, 32'hFF00FF00);

    stall = 1'b1;
    set_in(1'b1, 4'h2, 4'd0, 4'd0, 1'b1, 32'h1, 32'h1, 32'h99, 4'h7);
    tick();
    chk("stall_valE", out_valE, 32'hFF00FF00);
    chk("stall_icode", out_icode, 4'h6);
    chk("stall_valA", out_valA, 32'h11);
    chk("stall_dstE", out_dstE, 4'h6);
    chk("stall_cc", cc, 3'b010);

    bubble = 1'b1;
    tick();
    chk("stallbub_valid", out_valid, 1'b1);
    chk("stallbub_valE", out_valE, 32'hFF00FF00);

    stall = 1'b0;
    tick();
    chk("bub_valid", out_valid, 1'b0);
    chk("bub_icode", out_icode, 4'h1);
    chk("bub_valE", out_valE, 32'h0);
    chk("bub_valA", out_valA, 32'h0);
    chk("bub_dstE", out_dstE, 4'hF);
    chk("bub_cc", cc, 3'b010);
    bubble = 1'b0;

    // cc gating: blocked and invalid zero results leave cc alone
    cc_block = 1'b1;
    set_in(1'b1, 4'h6, 4'd1, 4'd0, 1'b1, 32'h5, 32'h5, 32'h0, 4'h2);
    tick();
    chk("ccblk_cc", cc, 3'b010);
    chk("ccblk_valid", out_valid, 1'b1);
    cc_block = 1'b0;

    set_in(1'b0, 4'h6, 4'd1, 4'd0, 1'b1, 32'h5, 32'h5, 32'h0, 4'h2);
    tick();
    chk("inv_cc", cc, 3'b010);
    chk("inv_valid", out_valid, 1'b0);
    chk("inv_icode", out_icode, 4'h1);

    // undefined alufun yields 0
    set_in(1'b1, 4'h6, 4'd5, 4'd0, 1'b1, 32'h7, 32'h9, 32'h0, 4'h2);
    tick();
    chk("fn5_valE", out_valE, 32'h0);
    chk("fn5_cc", cc, 3'b100);

    // sub overflow 80000000 - 1
    set_in(1'b1, 4'h6, 4'd1, 4'd0, 1'b1, 32'h80000000, 32'h1, 32'h0, 4'h2);
    tick();
    chk("subov_valE", out_valE, 32'h7FFFFFFF);
    chk("subov_cc", cc, 3'b001);

    set_in(1'b1, 4'h6, 4'd2, 4'd0, 1'b1, 32'hF0, 32'h3C, 32'h0, 4'h2);
    tick();
    chk("and_valE", out_valE, 32'h30);
    chk("and_cc", cc, 3'b000);

    // reset mid-stream with stall high
    set_in(1'b1, 4'h6, 4'd0, 4'd0, 1'b1, 32'h10, 32'h20, 32'h44, 4'h2);
    rst = 1'b1; stall = 1'b1;
    tick();
    chk_reset_state("midrst");

    rst = 1'b0; stall = 1'b0;
    set_in(1'b1, 4'h6, 4'd0, 4'd0, 1'b0, 32'h2, 32'h3, 32'h8, 4'h9);
    tick();
    chk("postrst_valid", out_valid, 1'b1);
    chk("postrst_valE", out_valE, 32'h5);
    chk("postrst_dstE", out_dstE, 4'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
